// File: rtl/moore_stream_ctrl_if.sv
// Word stream handshake between a word source and the serializing controller.
interface moore_stream_ctrl_if #(
   parameter int WORD_W = 8
);
   logic              word_valid;
   logic [WORD_W-1:0] word_data;
   logic              word_last;
   logic              word_ready;

   modport master (
      output word_valid,
      output word_data,
      output word_last,
      input  word_ready
   );

   modport slave (
      input  word_valid,
      input  word_data,
      input  word_last,
      output word_ready
   );
endinterface

// File: rtl/moore_stream_ctrl.sv
// Serializes a stream of words MSB-first into an external Moore detector and
// counts its detections. The detector is held in reset whenever no bit is being
// presented, so a pattern never spans a stall between words.
module moore_stream_ctrl #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   moore_stream_ctrl_if.slave wif,
   output logic               det_reset,
   output logic               det_inbit,
   input  logic               det_detect,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   match_count,
   output logic               overflow
);
   localparam int               BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_SHIFT, S_GAP, S_DRAIN, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              load;
   logic [WORD_W-1:0] buf_q, sh_q;
   logic              buf_full_q, buf_last_q, sh_last_q, last_acc_q;
   logic              sample_q, ovf_q;
   logic [BIT_W-1:0]  bit_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W:0]    cnt_inc;
   logic              job_start, accept, last_bit;

   // Saturating increment; the top bit flags an increment attempted at the ceiling.
   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == CNT_MAX) sat_inc = {1'b1, c};
      else              sat_inc = {1'b0, c + 1'b1};
   endfunction

   assign job_start   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign accept      = wif.word_valid && wif.word_ready;
   assign last_bit    = (bit_q == LAST_BIT);
   assign cnt_inc     = sat_inc(cnt_q);
   assign match_count = cnt_q;
   assign overflow    = ovf_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state, plus the buffer-to-shifter load that accompanies entering a word.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CLR;
         S_CLR: begin
            load    = buf_full_q;
            state_d = buf_full_q ? S_SHIFT : S_GAP;
         end
         S_SHIFT: begin
            if (last_bit) begin
               if (sh_last_q) begin
                  state_d = S_DRAIN;
               end else if (buf_full_q) begin
                  load    = 1'b1;
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            load    = buf_full_q;
            state_d = buf_full_q ? S_SHIFT : S_GAP;
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = start ? S_CLR : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state and registered flags only.
   always_comb begin
      busy           = (state_q == S_CLR) || (state_q == S_SHIFT) ||
                       (state_q == S_GAP) || (state_q == S_DRAIN);
      det_reset      = !((state_q == S_SHIFT) || (state_q == S_DRAIN));
      det_inbit      = (state_q == S_SHIFT) && sh_q[WORD_W-1];
      done           = (state_q == S_DONE);
      wif.word_ready = busy && !buf_full_q && !last_acc_q;
   end

   // Control: buffer occupancy, end-of-job marker, detect sampling and the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full_q <= 1'b0;
         last_acc_q <= 1'b0;
         sample_q   <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         sample_q <= (state_q == S_SHIFT);
         if (job_start) begin
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            last_acc_q <= 1'b0;
            buf_full_q <= 1'b0;
         end else begin
            if (sample_q && det_detect) begin
               cnt_q <= cnt_inc[CNT_W-1:0];
               if (cnt_inc[CNT_W]) ovf_q <= 1'b1;
            end
            if (accept) begin
               buf_full_q <= 1'b1;
               last_acc_q <= last_acc_q | wif.word_last;
            end else if (load) begin
               buf_full_q <= 1'b0;
            end
         end
      end
   end

   // Data: prefetch buffer capture and the MSB-first shifter with its bit index.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q      <= wif.word_data;
         buf_last_q <= wif.word_last;
      end
      if (load) begin
         sh_q      <= buf_q;
         sh_last_q <= buf_last_q;
         bit_q     <= '0;
      end else if (state_q == S_SHIFT) begin
         sh_q  <= sh_q << 1;
         bit_q <= bit_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_moore_stream_ctrl.sv
// Bench for moore_stream_ctrl: two instances (8-bit and 2-bit counters) run in
// lockstep against behavioural "101" detectors; a scoreboard holds per-job results.
module tb_moore_stream_ctrl;
   localparam int WORD_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1, start = 1'b0, vld = 1'b0, last = 1'b0;
   logic [WORD_W-1:0] data = '0;

   always #5 clk = ~clk;

   moore_stream_ctrl_if #(.WORD_W(WORD_W)) wif8 ();
   moore_stream_ctrl_if #(.WORD_W(WORD_W)) wif2 ();

   assign wif8.word_valid = vld;
   assign wif8.word_data  = data;
   assign wif8.word_last  = last;
   assign wif2.word_valid = vld;
   assign wif2.word_data  = data;
   assign wif2.word_last  = last;

   logic       dr8, di8, dd8, busy8, done8, ovf8;
   logic       dr2, di2, dd2, busy2, done2, ovf2;
   logic [7:0] mc8;
   logic [1:0] mc2;

   moore_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .wif(wif8),
      .det_reset(dr8), .det_inbit(di8), .det_detect(dd8),
      .busy(busy8), .done(done8), .match_count(mc8), .overflow(ovf8)
   );

   moore_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .wif(wif2),
      .det_reset(dr2), .det_inbit(di2), .det_detect(dd2),
      .busy(busy2), .done(done2), .match_count(mc2), .overflow(ovf2)
   );

   // "101" overlapping detector: state = length of the pattern prefix matched.
   function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
      case (s)
         2'd0:    return b ? 2'd1 : 2'd0;
         2'd1:    return b ? 2'd1 : 2'd2;
         2'd2:    return b ? 2'd3 : 2'd0;
         default: return b ? 2'd1 : 2'd2;
      endcase
   endfunction

   logic [1:0] ds8 = 2'd0, ds2 = 2'd0;
   always @(posedge clk) ds8 <= dr8 ? 2'd0 : det_next(ds8, di8);
   always @(posedge clk) ds2 <= dr2 ? 2'd0 : det_next(ds2, di2);
   assign dd8 = (ds8 == 2'd3);
   assign dd2 = (ds2 == 2'd3);

   int checks = 0, failures = 0;

   typedef struct {
      int c8; int o8; int c2; int o2; int nb;
   } exp_t;
   exp_t expq[$];

   logic [WORD_W-1:0] jw[$];
   bit                jg[$];
   bit                jmid;
   bit                mon_en = 1'b0;
   int                nb = 0;
   logic              done_prev = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int cnt101(input bit b[$]);
      int n = 0;
      for (int i = 2; i < b.size(); i++)
         if (b[i-2] && !b[i-1] && b[i]) n++;
      return n;
   endfunction

   // Monitor: per-cycle protocol checks and job results popped at each done pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("inbit_while_det_reset", (dr8 && di8) ? 1 : 0, 0);
         chk("ready_while_not_busy", (wif8.word_ready && !busy8) ? 1 : 0, 0);
         chk("done_single_cycle", (done8 && done_prev) ? 1 : 0, 0);
         chk("dut2_lockstep", (busy2 != busy8 || wif2.word_ready != wif8.word_ready) ? 1 : 0, 0);
         done_prev <= done8;
         if (reset) nb <= 0;
         else if (busy8 && !dr8) nb <= nb + 1;
         if (done8) begin
            nb <= 0;
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("match_count_w8", int'(mc8), e.c8);
               chk("overflow_w8", int'(ovf8), e.o8);
               chk("match_count_w2", int'(mc2), e.c2);
               chk("overflow_w2", int'(ovf2), e.o2);
               chk("done_w2", int'(done2), 1);
               chk("bit_cycles", nb, e.nb);
            end
         end
      end
   end

   task automatic send_word(input logic [WORD_W-1:0] d, input logic l, input bit st);
      bit ok = 1'b0;
      bit r;
      vld   = 1'b1;
      data  = d;
      last  = l;
      start = st;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         r = wif8.word_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      vld  = 1'b0;
      last = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL word_accept_timeout actual=0 required=1");
      end
   endtask

   task automatic run_job();
      int   total = 0;
      bit   seg[$];
      exp_t e;
      bit   ok = 1'b0;
      for (int i = 0; i < jw.size(); i++) begin
         if (i > 0 && jg[i]) begin
            total += cnt101(seg);
            seg.delete();
         end
         for (int k = WORD_W - 1; k >= 0; k--) seg.push_back(jw[i][k]);
      end
      total += cnt101(seg);
      e.c8 = (total > 255) ? 255 : total;
      e.o8 = (total > 255) ? 1 : 0;
      e.c2 = (total > 3) ? 3 : total;
      e.o2 = (total > 3) ? 1 : 0;
      e.nb = WORD_W * jw.size() + 1;
      expq.push_back(e);

      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < jw.size(); i++) begin
         if (i > 0 && jg[i]) begin
            repeat (2 * WORD_W + 4) @(posedge clk);
            #1;
         end
         send_word(jw[i], (i == jw.size() - 1), jmid && (i == 1));
      end
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (done8) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=0 required=1");
      end
      @(posedge clk); #1;
   endtask

   // Stimulus: reset, directed jobs, mid-job reset, then randomized jobs.
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy8), 0);
      chk("rst_ready", int'(wif8.word_ready), 0);
      chk("rst_det_reset", int'(dr8), 1);
      chk("rst_det_inbit", int'(di8), 0);
      chk("rst_done", int'(done8), 0);
      chk("rst_count", int'(mc8), 0);
      chk("rst_overflow", int'(ovf8), 0);
      @(posedge clk); #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      jmid = 1'b0;
      jw = {8'hAA};         jg = {1'b0};        run_job();
      jw = {8'h01, 8'h7F};  jg = {1'b0, 1'b0};  run_job();
      jw = {8'h01, 8'h7F};  jg = {1'b0, 1'b1};  run_job();
      jw = {8'hAA, 8'hAA};  jg = {1'b0, 1'b0};  run_job();

      vld  = 1'b1;
      data = 8'h5A;
      repeat (4) begin
         @(negedge clk);
         chk("ready_idle_with_valid", int'(wif8.word_ready), 0);
      end
      @(posedge clk); #1;
      jw = {8'h5A, 8'hB5, 8'h6D}; jg = {1'b0, 1'b0, 1'b0}; jmid = 1'b1; run_job();
      jmid = 1'b0;

      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      send_word(8'h3C, 1'b0, 1'b0);
      send_word(8'hA5, 1'b1, 1'b0);
      repeat (WORD_W + 2) @(posedge clk);
      #1;
      reset = 1'b1;
      vld   = 1'b1;
      data  = 8'hFF;
      last  = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vld   = 1'b0;
      last  = 1'b0;
      @(negedge clk);
      chk("midrst_busy", int'(busy8), 0);
      chk("midrst_ready", int'(wif8.word_ready), 0);
      chk("midrst_det_reset", int'(dr8), 1);
      chk("midrst_count", int'(mc8), 0);
      chk("midrst_overflow", int'(ovf8), 0);
      repeat (20) @(posedge clk);
      #1;
      jw = {8'h3C, 8'hA5}; jg = {1'b0, 1'b0}; run_job();

      for (int j = 0; j < 25; j++) begin
         int n;
         n = $urandom_range(1, 4);
         jw.delete();
         jg.delete();
         for (int i = 0; i < n; i++) begin
            jw.push_back(WORD_W'($urandom));
            jg.push_back($urandom_range(0, 3) == 0);
         end
         jmid = ($urandom_range(0, 1) == 1);
         run_job();
      end

      repeat (5) @(posedge clk);
      chk("pending_jobs", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/moore_stream_ctrl.md
MOORE_STREAM_CTRL -- requirements
Module: moore_stream_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, width of each serialized input word.
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  begin a job; sampled only in IDLE or DONE.
REQ-006 SHALL have port word_valid  in  1  word_data/word_last valid.
REQ-007 SHALL have port word_data  in  WORD_W  word to serialize, MSB first.
REQ-008 SHALL have port word_last  in  1  marks final word of the job.
REQ-009 SHALL have port word_ready  out  1  controller accepts the word this cycle.
REQ-010 SHALL have port det_reset  out  1  drives the detector's reset input.
REQ-011 SHALL have port det_inbit  out  1  drives the detector's inbit input.
REQ-012 SHALL have port det_detect  in  1  Moore detect output of the detector.
REQ-013 SHALL have port busy  out  1  high from CLR through DRAIN.
REQ-014 SHALL have port done  out  1  one-cycle pulse at job end.
REQ-015 SHALL have port match_count  out  CNT_W  detections counted in the current or last job.
REQ-016 SHALL have port overflow  out  1  sticky; match_count saturated.

Function
REQ-017 SHALL implement states IDLE, CLR, SHIFT, GAP, DRAIN, DONE.
REQ-018 Transfer SHALL occur on a cycle with word_valid and word_ready both high; word_ready SHALL not depend combinationally on word_valid.
REQ-019 SHALL hold a one-word prefetch buffer; word_ready = busy and buffer empty and no word_last yet accepted in this job.
REQ-020 start in IDLE/DONE SHALL clear match_count and overflow, and enter CLR; start in any other state SHALL be ignored.
REQ-021 CLR SHALL last exactly one cycle with det_reset=1, then go to SHIFT if the buffer is full, else to GAP.
REQ-022 SHIFT SHALL present one bit per cycle on det_inbit, MSB first, det_reset=0, for WORD_W cycles per word.
REQ-023 On the last bit of a word: if that word had word_last, go to DRAIN; else if the buffer is full, load it and continue SHIFT with no idle cycle; else go to GAP.
REQ-024 GAP SHALL hold det_reset=1 and det_inbit=0 each cycle (patterns SHALL NOT span a gap); exit to SHIFT the cycle after the buffer fills.
REQ-025 DRAIN SHALL last one cycle with det_inbit=0, det_reset=0; next state DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then go to IDLE; match_count and overflow SHALL hold until the next start.
REQ-027 Sample rule: det_detect SHALL be counted in cycle t iff cycle t-1 was a SHIFT cycle (bit presented with det_reset=0).
REQ-028 The count SHALL therefore cover the detect following the final bit (sampled in DRAIN) and never count in CLR/GAP/IDLE follow-on cycles.
REQ-029 match_count SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set overflow.
REQ-030 Outside SHIFT, det_inbit SHALL be 0; det_reset SHALL be 1 in IDLE, CLR, GAP, DONE.

Reset
REQ-031 While reset is high at a clock edge, state SHALL become IDLE, the buffer empty, match_count=0, overflow=0.
REQ-032 Outputs after reset: word_ready=0, det_reset=1, det_inbit=0, busy=0, done=0.
REQ-033 Reset mid-job SHALL abandon the job with no done pulse; a word presented in that cycle SHALL NOT be accepted.

Verification
Bench uses a behavioural Moore "101" overlapping detector on det_* with detect registered one cycle after the bit.
REQ-034 start, one word 8'hAA with last -> 8 SHIFT cycles, DRAIN, done pulse; match_count=3, overflow=0.
REQ-035 Words 8'h01 then 8'h7F back-to-back, last on second -> no gap; match_count=1 (pattern spans the boundary).
REQ-036 Same words with 3 idle cycles between them -> GAP with det_reset=1; match_count=0.
REQ-037 CNT_W=2, words 8'hAA, 8'hAA back-to-back -> match_count=3, overflow=1 at done.
REQ-038 reset asserted during SHIFT of the second word -> next cycle IDLE, count 0, no done pulse; a new start runs a clean job.
REQ-039 start asserted while busy, and word_valid held high in IDLE -> both ignored, word_ready stays 0, job result unchanged.
